// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State encoding, abort read pattern and default wait limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERV_IF = 2'd1,
        SERV_DM = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_DATA   = 32'hDEAD_BEEF;
    localparam int          DEF_MAX_WAIT = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and single-port memory signals around the arbiter.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;

    logic [31:0] rdata;
    logic        err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, dm_ack, rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, dm_ack, rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection between fetch and data requests.
// ARB_RR_EN: alternate on contention; otherwise data always wins.
module arb_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic last_dm,
    output logic grant_if,
    output logic grant_dm
);

`ifdef ARB_RR_EN
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (if_req && dm_req) begin
            grant_if = last_dm;
            grant_dm = !last_dm;
        end else begin
            grant_if = if_req;
            grant_dm = dm_req;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_dm;
    assign grant_dm    = dm_req;
    assign grant_if    = if_req && !dm_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port memory.
// Optional round-robin contention policy via ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_inc;
    logic        last_dm;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic        req_if;
    logic        req_dm;
    logic        grant_if;
    logic        grant_dm;
    logic        serving;
    logic        abort;
    logic        finish;

    // A request still high in its own ack cycle is the finished one.
    assign req_if  = bus.if_req && !bus.if_ack;
    assign req_dm  = bus.dm_req && !bus.dm_ack;

    assign serving = (state != IDLE);
    assign cnt_inc = cnt + 4'd1;
    assign abort   = serving && !bus.mem_ready && (cnt_inc == LIMIT);
    assign finish  = serving && (bus.mem_ready || abort);

    arb_pick u_pick (
        .if_req   (req_if),
        .dm_req   (req_dm),
        .last_dm  (last_dm),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nxt = SERV_DM;
                end else if (grant_if) begin
                    state_nxt = SERV_IF;
                end
            end
            SERV_IF, SERV_DM: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req   = serving;
        bus.mem_we    = serving && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt        <= '0;
            last_dm    <= 1'b0;
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            bus.err    <= 1'b0;
            if (!serving) begin
                if (grant_dm) begin
                    addr_q  <= bus.dm_addr;
                    we_q    <= bus.dm_we;
                    wdata_q <= bus.dm_wdata;
                    cnt     <= '0;
                end else if (grant_if) begin
                    addr_q  <= bus.if_addr;
                    we_q    <= 1'b0;
                    cnt     <= '0;
                end
            end else begin
                if (!bus.mem_ready) begin
                    cnt <= cnt_inc;
                end
                if (finish) begin
                    bus.if_ack <= (state == SERV_IF);
                    bus.dm_ack <= (state == SERV_DM);
                    bus.err    <= abort;
                    last_dm    <= (state == SERV_DM);
                    if (abort) begin
                        bus.rdata <= ABORT_DATA;
                    end else if (!we_q) begin
                        bus.rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter, MAX_WAIT = 3.
// Works in both the fixed-priority and ARB_RR_EN builds.
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;
    logic first_if;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_WAIT(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
`ifdef ARB_RR_EN
        first_if = 1'b1;
`else
        first_if = 1'b0;
`endif
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        step();
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_if_ack", 32'(bus.if_ack), 0);
        chk("rst_dm_ack", 32'(bus.dm_ack), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        step();

        // Single fetch, memory always ready
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1234;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h40;
        step();
        chk("f_mem_req", 32'(bus.mem_req), 1);
        chk("f_mem_addr", bus.mem_addr, 32'h40);
        chk("f_mem_we", 32'(bus.mem_we), 0);
        chk("f_early_ack", 32'(bus.if_ack), 0);
        step();
        chk("f_if_ack", 32'(bus.if_ack), 1);
        chk("f_dm_ack", 32'(bus.dm_ack), 0);
        chk("f_rdata", bus.rdata, 32'h1234);
        chk("f_err", 32'(bus.err), 0);
        chk("f_idle_req", 32'(bus.mem_req), 0);
        bus.if_req = 1'b0;
        step();
        chk("f_ack_pulse", 32'(bus.if_ack), 0);

        // Simultaneous store and fetch: store first
        bus.mem_rdata = 32'h5555;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h80;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b1;
        bus.dm_addr   = 32'h100;
        bus.dm_wdata  = 32'hAA;
        step();
        chk("s_mem_addr", bus.mem_addr, 32'h100);
        chk("s_mem_we", 32'(bus.mem_we), 1);
        chk("s_mem_wdata", bus.mem_wdata, 32'hAA);
        step();
        chk("s_dm_ack", 32'(bus.dm_ack), 1);
        chk("s_if_ack", 32'(bus.if_ack), 0);
        chk("s_rdata_hold", bus.rdata, 32'h1234);
        bus.dm_req = 1'b0;
        step();
        chk("s2_mem_addr", bus.mem_addr, 32'h80);
        chk("s2_mem_we", 32'(bus.mem_we), 0);
        chk("s2_dm_ack", 32'(bus.dm_ack), 0);
        step();
        chk("s2_if_ack", 32'(bus.if_ack), 1);
        chk("s2_rdata", bus.rdata, 32'h5555);
        bus.if_req = 1'b0;
        step();

        // Both held: DM, IF, DM
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h20;
        step();
        chk("h1_addr", bus.mem_addr, 32'h20);
        step();
        chk("h1_dm_ack", 32'(bus.dm_ack), 1);
        step();
        chk("h2_addr", bus.mem_addr, 32'h10);
        step();
        chk("h2_if_ack", 32'(bus.if_ack), 1);
        chk("h2_one_ack", 32'(bus.dm_ack), 0);
        step();
        chk("h3_addr", bus.mem_addr, 32'h20);
        step();
        chk("h3_dm_ack", 32'(bus.dm_ack), 1);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        step();

        // Contention after a DM service: policy dependent
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h700;
        step();
        chk("p1_addr", bus.mem_addr, first_if ? 32'h600 : 32'h700);
        step();
        chk("p1_if_ack", 32'(bus.if_ack), 32'(first_if));
        chk("p1_dm_ack", 32'(bus.dm_ack), 32'(!first_if));
        if (first_if) bus.if_req = 1'b0;
        else          bus.dm_req = 1'b0;
        step();
        chk("p2_addr", bus.mem_addr, first_if ? 32'h700 : 32'h600);
        step();
        chk("p2_if_ack", 32'(bus.if_ack), 32'(!first_if));
        chk("p2_dm_ack", 32'(bus.dm_ack), 32'(first_if));
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        step();

        // Timeout abort after 3 wait cycles
        bus.mem_ready = 1'b0;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h200;
        step();
        chk("a_req1", 32'(bus.mem_req), 1);
        step();
        chk("a_req2", 32'(bus.mem_req), 1);
        step();
        chk("a_req3", 32'(bus.mem_req), 1);
        chk("a_no_ack", 32'(bus.dm_ack), 0);
        step();
        chk("a_dm_ack", 32'(bus.dm_ack), 1);
        chk("a_err", 32'(bus.err), 1);
        chk("a_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk("a_idle", 32'(bus.mem_req), 0);
        bus.dm_req = 1'b0;
        step();
        chk("a_err_pulse", 32'(bus.err), 0);

        // Ready delayed two cycles
        bus.mem_rdata = 32'hCAFE;
        bus.dm_req    = 1'b1;
        bus.dm_addr   = 32'h300;
        step();
        chk("d_req1", 32'(bus.mem_req), 1);
        step();
        chk("d_req2", 32'(bus.mem_req), 1);
        chk("d_no_ack2", 32'(bus.dm_ack), 0);
        step();
        bus.mem_ready = 1'b1;
        chk("d_req3", 32'(bus.mem_req), 1);
        chk("d_no_ack3", 32'(bus.dm_ack), 0);
        step();
        chk("d_dm_ack", 32'(bus.dm_ack), 1);
        chk("d_err", 32'(bus.err), 0);
        chk("d_rdata", bus.rdata, 32'hCAFE);
        bus.dm_req = 1'b0;
        step();
        chk("d_single_ack", 32'(bus.dm_ack), 0);

        // Reset in the middle of a data access
        bus.mem_ready = 1'b0;
        bus.dm_req    = 1'b1;
        bus.dm_addr   = 32'h400;
        step();
        chk("r_req_before", 32'(bus.mem_req), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_req_async", 32'(bus.mem_req), 0);
        chk("r_addr_clr", bus.mem_addr, 0);
        bus.dm_req = 1'b0;
        step();
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        chk("r_no_ack", 32'(bus.dm_ack), 0);
        chk("r_no_err", 32'(bus.err), 0);
        step();
        chk("r_idle_ready", 32'(bus.dm_ack | bus.if_ack), 0);
        bus.mem_rdata = 32'h77;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h500;
        step();
        chk("r2_addr", bus.mem_addr, 32'h500);
        step();
        chk("r2_if_ack", 32'(bus.if_ack), 1);
        chk("r2_rdata", bus.rdata, 32'h77);
        bus.if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory cycles waited for mem_ready before abort (1..15).
REQ-002 clock  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 if_req  input  1  fetch-stage read request, held until if_ack.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_ack  output  1  one-cycle pulse: fetch done, rdata valid.
REQ-007 dm_req  input  1  MEM-stage access request, held until dm_ack.
REQ-008 dm_we  input  1  1 = store, 0 = load.
REQ-009 dm_addr  input  32  data address.
REQ-010 dm_wdata  input  32  store data.
REQ-011 dm_ack  output  1  one-cycle pulse: data access done.
REQ-012 rdata  output  32  registered read data, shared by both requesters.
REQ-013 err  output  1  one-cycle pulse with the ack of an aborted access.
REQ-014 mem_req  output  1  single-port memory request.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-019 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-020 FSM states: IDLE, SERV_IF, SERV_DM; exactly one state at a time.
REQ-021 IDLE with dm_req=1: next state SERV_DM; with only if_req=1: SERV_IF; neither: stay IDLE.
REQ-022 On grant, addr/we/wdata are latched; mem_* outputs are driven from the latches, and mem_req=1 throughout SERV_*.
REQ-023 IF grants force mem_we=0; mem_wdata is don't-care for loads and fetches.
REQ-024 In SERV_* with mem_ready=1: next cycle the matching ack=1, rdata=mem_rdata (loads/fetches only; rdata holds on stores), state IDLE.
REQ-025 Latency: with mem_ready tied 1, ack is asserted 2 cycles after a request is sampled in IDLE; back-to-back grants are spaced 2 cycles apart.
REQ-026 4-bit wait counter clears on grant and increments each SERV_* cycle with mem_ready=0.
REQ-027 When the counter reaches MAX_WAIT: abort; next cycle ack=1, err=1, rdata=32'hDEAD_BEEF, state IDLE.
REQ-028 mem_ready while in IDLE is ignored.
REQ-029 At most one of if_ack/dm_ack is high in any cycle.
REQ-030 A request deasserted before its ack is a protocol violation; no recovery is required.

Reset
REQ-031 reset=1 immediately forces IDLE; mem_req, mem_we, if_ack, dm_ack, err = 0; rdata, mem_addr, mem_wdata = 0; wait counter = 0; last-served flag = IF.
REQ-032 Reset mid-access drops the access silently: no ack and no err.

Configuration
REQ-033 Macro ARB_RR_EN undefined: fixed priority, DM always wins simultaneous requests.
REQ-034 ARB_RR_EN defined: on simultaneous requests, grant the requester not served last; the last-served flag updates on each ack; after reset DM wins first.

Structure
REQ-035 Shared package holds the state encoding (2-bit IDLE=0, SERV_IF=1, SERV_DM=2), the abort pattern 32'hDEAD_BEEF and the default MAX_WAIT.
REQ-036 One sub-module, arb_pick: combinational grant selection from if_req, dm_req and the last-served flag; the FSM, latches and counter stay in mem_arbiter.

Verification
REQ-037 mem_ready=1; if_req alone, if_addr=0x40, mem_rdata=0x1234 -> mem_addr=0x40, mem_we=0; if_ack 2 cycles later; rdata=0x1234.
REQ-038 if_req and dm_req together, dm_we=1, dm_addr=0x100, dm_wdata=0xAA -> DM served first (mem_we=1, mem_wdata=0xAA), then IF; ARB_RR_EN build with requests held -> grants alternate DM, IF, DM.
REQ-039 mem_ready held 0, MAX_WAIT=3 -> after 3 wait cycles, ack=1, err=1, rdata=0xDEADBEEF; state returns to IDLE.
REQ-040 mem_ready delayed 2 cycles on a load -> mem_req held for 3 cycles, a single dm_ack, no err.
REQ-041 reset pulsed during SERV_DM -> mem_req=0 in the same cycle, no ack afterwards, next request served normally.
